// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle for alu_exec_unit.
// master: the issuing stage drives start/opcode/operands.
// slave:  the execution unit returns busy/done/zWrite/result/carry.
// WIDTH must match the WIDTH of the alu_exec_unit it connects to.
interface alu_exec_unit_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             zWrite;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output start,
        output opcode,
        output opA,
        output opB,
        input  busy,
        input  done,
        input  zWrite,
        input  result,
        input  carry
    );

    modport slave (
        input  start,
        input  opcode,
        input  opA,
        input  opB,
        output busy,
        output done,
        output zWrite,
        output result,
        output carry
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage feeding the zero-flag register.
// Single-cycle ADD/SUB/AND/OR/XOR/INC/DEC, iterative shift-add MUL (WIDTH+1 cycle latency).
// zWrite pulses with done and acts as the zero-flag register's write enable; result is its data.
// Build option: define ALU_SATURATE_EN to clamp overflowing ADD/INC/MUL to all-ones and
// underflowing SUB/DEC to zero; carry still flags the overflow/underflow.
module alu_exec_unit #(
    parameter int WIDTH = 12
) (
    input logic           clock,
    input logic           rst,
    alu_exec_unit_if.slave bus
);

`ifdef ALU_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpInc = 3'b101;
    localparam logic [2:0] OpDec = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StMulRun,
        StDone
    } state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   mcand_q;   // multiplicand, pre-shifted by the iteration count
    logic [WIDTH-1:0]     mplier_q;  // multiplier, consumed LSB first
    logic [2*WIDTH-1:0]   acc_q;
    logic [CntW-1:0]      count_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;

    // Single-cycle datapath, evaluated on the live inputs
    logic [WIDTH:0]       alu_wide;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 clamp_hi;
    logic                 clamp_lo;

    // Multiplier step
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mul_res;
    logic                 mul_carry;
    logic                 mul_last;

    // Decode opcode and compute the one-cycle result, borrow/carry and optional clamp
    always_comb begin
        alu_wide  = '0;
        alu_carry = 1'b0;
        clamp_hi  = 1'b0;
        clamp_lo  = 1'b0;
        unique case (bus.opcode)
            OpAdd: begin
                alu_wide  = {1'b0, bus.opA} + {1'b0, bus.opB};
                alu_carry = alu_wide[WIDTH];
                clamp_hi  = 1'b1;
            end
            OpSub: begin
                // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow
                alu_wide  = {1'b0, bus.opA} - {1'b0, bus.opB};
                alu_carry = alu_wide[WIDTH];
                clamp_lo  = 1'b1;
            end
            OpAnd: alu_wide = {1'b0, bus.opA & bus.opB};
            OpOr:  alu_wide = {1'b0, bus.opA | bus.opB};
            OpXor: alu_wide = {1'b0, bus.opA ^ bus.opB};
            OpInc: begin
                alu_wide  = {1'b0, bus.opA} + {{WIDTH{1'b0}}, 1'b1};
                alu_carry = alu_wide[WIDTH];
                clamp_hi  = 1'b1;
            end
            OpDec: begin
                alu_wide  = {1'b0, bus.opA} - {{WIDTH{1'b0}}, 1'b1};
                alu_carry = alu_wide[WIDTH];
                clamp_lo  = 1'b1;
            end
            OpMul: alu_wide = '0;  // handled by the iterative path
        endcase
        alu_res = alu_wide[WIDTH-1:0];
        if (SatEn && alu_carry && clamp_hi) begin
            alu_res = '1;
        end else if (SatEn && alu_carry && clamp_lo) begin
            alu_res = '0;
        end
    end

    // One shift-add iteration plus the final-result view of it
    always_comb begin
        acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_carry = |acc_next[2*WIDTH-1:WIDTH];
        mul_res   = acc_next[WIDTH-1:0];
        if (SatEn && mul_carry) begin
            mul_res = '1;
        end
        mul_last  = (count_q == CntW'(WIDTH - 1));
    end

    // Control FSM with registered outputs; result/carry only move on entry to StDone
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.opcode == OpMul) begin
                            mcand_q  <= {{WIDTH{1'b0}}, bus.opA};
                            mplier_q <= bus.opB;
                            acc_q    <= '0;
                            count_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= StMulRun;
                        end else begin
                            result_q <= alu_res;
                            carry_q  <= alu_carry;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
                StMulRun: begin
                    // start is ignored here; all WIDTH bits are processed, no early exit
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CntW'(1);
                    if (mul_last) begin
                        result_q <= mul_res;
                        carry_q  <= mul_carry;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // start is ignored for this cycle
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.zWrite = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed boundary cases plus randomized ops,
// checked against an arithmetic reference model. Honors ALU_SATURATE_EN like the design.
module tb_alu_exec_unit;
    localparam int W = 12;
    localparam longint unsigned Lim = 64'd1 << W;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic zflag = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   zw_count = 0;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Downstream zero-flag register as wired in the core
    always @(posedge clock) begin
        if (bus.zWrite) zflag <= (bus.result == '0);
    end

    always @(negedge clock) begin
        if (bus.zWrite) zw_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on integers
    function automatic void ref_op(input logic [2:0] op, input longint unsigned a,
                                   input longint unsigned b, output longint unsigned res,
                                   output longint unsigned cy);
        longint unsigned full;
        bit over, under;
        over = 0;
        under = 0;
        cy = 0;
        case (op)
            3'd0: begin full = a + b; over = (full >= Lim); res = full % Lim; end
            3'd1: begin under = (a < b); res = (a + Lim - b) % Lim; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin full = a + 1; over = (full >= Lim); res = full % Lim; end
            3'd6: begin under = (a < 1); res = (a + Lim - 1) % Lim; end
            default: begin full = a * b; over = (full >= Lim); res = full % Lim; end
        endcase
        cy = (over || under) ? 1 : 0;
`ifdef ALU_SATURATE_EN
        if (over) res = Lim - 1;
        if (under) res = 0;
`endif
    endfunction

    // Issue one op at the current negedge; end one negedge after the done pulse
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise);
        longint unsigned er, ec;
        int lat;
        ref_op(op, a, b, er, ec);
        lat = (op == 3'b111) ? W + 1 : 1;
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.opA    = a;
        bus.opB    = b;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clock);
            if (n < lat) begin
                check("done_early", bus.done, 1'b0);
                check("busy_run", bus.busy, 1'b1);
            end else begin
                check("done", bus.done, 1'b1);
                check("zwrite", bus.zWrite, 1'b1);
                check("busy_done", bus.busy, 1'b0);
                check("result", bus.result, er[W-1:0]);
                check("carry", bus.carry, ec[0]);
            end
            // Latched operands must not follow the inputs after accept
            bus.start  = (noise && n < lat) ? 1'b1 : 1'b0;
            bus.opcode = 3'($urandom_range(0, 7));
            bus.opA    = W'($urandom_range(0, int'(Lim) - 1));
            bus.opB    = W'($urandom_range(0, int'(Lim) - 1));
        end
        @(negedge clock);
        check("done_pulse", bus.done, 1'b0);
        check("zwrite_pulse", bus.zWrite, 1'b0);
        check("result_hold", bus.result, er[W-1:0]);
        check("zflag", zflag, (er == 0) ? 1'b1 : 1'b0);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return W'(1);
            default: return W'($urandom_range(0, int'(Lim) - 1));
        endcase
    endfunction

    initial begin
        int zw_base;
        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.opA    = '0;
        bus.opB    = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_zwrite", bus.zWrite, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_carry", bus.carry, 1'b0);
        rst = 1'b0;
        @(negedge clock);

        // Directed boundary cases
        do_op(3'd0, 12'hFFF, 12'h001, 1'b0);  // wraps to 0 (or clamps), carry
        do_op(3'd1, 12'h005, 12'h007, 1'b0);  // borrow
        do_op(3'd7, 12'h012, 12'h034, 1'b0);  // 0x3A8
        do_op(3'd7, 12'h100, 12'h010, 1'b0);  // upper half nonzero
        do_op(3'd7, 12'hABC, 12'h000, 1'b0);  // MUL by 0, full latency
        do_op(3'd5, 12'hFFF, 12'h000, 1'b0);
        do_op(3'd6, 12'h000, 12'h000, 1'b0);
        do_op(3'd7, 12'h0FF, 12'h00F, 1'b1);  // start spam during MUL

        // Back-to-back: second start is presented during DONE and must wait a cycle
        zw_base    = zw_count;
        bus.start  = 1'b1;
        bus.opcode = 3'd5;
        bus.opA    = 12'h7FF;
        bus.opB    = 12'h000;
        @(negedge clock);
        check("b2b_done1", bus.done, 1'b1);
        check("b2b_res1", bus.result, 12'h800);
        check("b2b_cy1", bus.carry, 1'b0);
        bus.opcode = 3'd2;
        bus.opA    = 12'hF0F;
        bus.opB    = 12'h0F0;
        @(negedge clock);
        check("b2b_gap", bus.done, 1'b0);
        @(negedge clock);
        check("b2b_done2", bus.done, 1'b1);
        check("b2b_res2", bus.result, 12'h000);
        check("b2b_cy2", bus.carry, 1'b0);
        bus.start = 1'b0;
        @(negedge clock);
        check("b2b_zw_count", 32'(zw_count - zw_base), 32'd2);

        // Async reset in the middle of a MUL
        do_op(3'd0, 12'h001, 12'h002, 1'b0);
        zw_base    = zw_count;
        bus.start  = 1'b1;
        bus.opcode = 3'd7;
        bus.opA    = 12'h005;
        bus.opB    = 12'h006;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_result", bus.result, '0);
        check("mid_rst_carry", bus.carry, 1'b0);
        @(negedge clock);
        rst = 1'b0;
        repeat (W + 4) @(negedge clock);
        check("mid_rst_no_done", 32'(zw_count - zw_base), 32'd0);
        do_op(3'd7, 12'h012, 12'h034, 1'b0);

        // Randomized ops
        for (int i = 0; i < 150; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution stage sitting directly upstream of the zero-flag register in each core.
- Accepts an opcode and two WIDTH-bit operands, computes the result, and registers it on `result`.
- On every completion it pulses `zWrite`, which wires straight to the zero-flag register's write enable, with `result` as that register's data input.
- Single-cycle ops finish in 1 cycle; MUL is an iterative shift-add taking WIDTH+1 cycles.

Parameters:
- WIDTH, 12, datapath width of operands and result.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- opcode  input  3  operation select, latched on accept.
- opA  input  WIDTH  operand A, latched on accept.
- opB  input  WIDTH  operand B, latched on accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- zWrite  output  1  one-cycle pulse, identical timing to done; drives the zero-flag register's writeEn.
- result  output  WIDTH  registered result, held until the next completion.
- carry  output  1  carry/borrow/overflow of the last completed op, held.

Behaviour:
- Reset (async, rst=1): FSM to IDLE; busy=0, done=0, zWrite=0, result=0, carry=0; operand, accumulator and counter registers cleared. Reset mid-MUL aborts the operation with no done pulse.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 INC: A+1.
  - 110 DEC: A-1.
  - 111 MUL: low WIDTH bits of A*B.
- Arithmetic is unsigned, computed at WIDTH+1 bits.
- carry per opcode:
  - ADD/INC: bit WIDTH of the sum.
  - SUB/DEC: borrow, 1 when the minuend is less than the subtrahend.
  - MUL: 1 if any bit of the upper WIDTH bits of the 2*WIDTH product is nonzero.
  - Logic ops: 0.
- FSM states: IDLE, MUL_RUN, DONE.
- IDLE:
  - start=1 with a non-MUL opcode: compute from the live inputs; result and carry register at this edge; go to DONE.
  - start=1 with MUL: latch A and B; clear the 2*WIDTH accumulator; count=0; busy=1; go to MUL_RUN.
  - start=0: stay in IDLE.
- MUL_RUN, each cycle:
  - If multiplier bit 0 is 1, add the multiplicand (shifted by count) into the accumulator.
  - Shift the multiplier right; count++.
  - When count reaches WIDTH-1 on this edge, the final partial product is applied, result and carry register, and the FSM goes to DONE.
- DONE: done=1, zWrite=1 for exactly this cycle; busy=0; next state IDLE.
  - start in DONE is ignored. Back-to-back throughput for single-cycle ops is therefore 1 op per 2 cycles.
- Latency from the start edge to done high:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles (13 at default).
- start while busy=1 is ignored; latched operands are unaffected by input changes after accept.
- result and carry change only at the edge entering DONE; otherwise they hold their value.
- Boundary cases:
  - MUL by 0: 0 after the full WIDTH+1 cycles, with no early exit.
  - 0xFFF+1 wraps to 0 with carry=1.
  - 0-1 wraps to all-ones with carry=1.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined:
  - ADD/INC/MUL overflow clamps result to all-ones.
  - SUB/DEC underflow clamps result to 0.
  - carry still reports that the overflow/underflow occurred.
  - Latency is unchanged.
- Undefined: wrap-around results as described in Behaviour.
- Logic ops are unaffected in both builds.

Test Plan:
- Reset: assert rst mid-MUL (cycle 5) -> busy=0 and result=0 immediately (async); no done pulse; next start is accepted normally.
- ADD opA=0xFFF, opB=0x001 -> one cycle later done=zWrite=1 for 1 cycle, result=0x000, carry=1; downstream zero flag reads 1 the following cycle. With ALU_SATURATE_EN: result=0xFFF, carry=1.
- SUB opA=0x005, opB=0x007 -> result=0xFFE, carry=1. With ALU_SATURATE_EN: result=0x000.
- MUL opA=0x012, opB=0x034 -> busy high for 12 cycles, done at cycle 13, result=0x3A8, carry=0. MUL 0x100*0x010 -> result=0x000, carry=1.
- start pulsed every cycle during a MUL with different operands -> all ignored; exactly one done; result matches the first accepted operands.
- Back-to-back INC 0x7FF then AND 0xF0F,0x0F0 -> done pulses 2 cycles apart; results 0x800 (carry=0) then 0x000 (carry=0); two zWrite pulses in total.
